// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state types shared by the sequential ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result handshake bundle of the sequential ALU
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             err;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative, err
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative, err
    );
endinterface

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - one combinational shift step of 1..STEP bits
module alu_shift_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic             right,
    input  logic             arith,
    output logic [WIDTH-1:0] data_out,
    output logic             out_bit
);

    // Unrolled over the legal step sizes so every bit index is a constant.
    always_comb begin
        data_out = data;
        out_bit  = 1'b0;
        for (int i = 1; i <= STEP; i++) begin
            if (amt == AMT_W'(i)) begin
                if (right) begin
                    data_out = arith ? unsigned'($signed(data) >>> i) : (data >> i);
                    out_bit  = data[i-1];
                end else begin
                    data_out = data << i;
                    out_bit  = data[WIDTH-i];
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle arithmetic/logic, multi-cycle shifts
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int STEP_W  = $clog2(SHIFT_STEP) + 1;

    alu_state_e         state_q, state_d;
    alu_op_e            op_q, op_d, op_in;
    logic [SHAMT_W-1:0] rem_q, rem_d, shamt;
    logic [WIDTH-1:0]   result_q, result_d, b_eff;
    logic [WIDTH:0]     sum;
    logic               carry_q, carry_d, overflow_q, overflow_d;
    logic               zero_q, zero_d, negative_q, negative_d, err_q, err_d;
    logic               accept, upd;
    logic [STEP_W-1:0]  step_amt;
    logic [WIDTH-1:0]   step_data;
    logic               step_bit;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.err       = err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign op_in    = alu_op_e'(bus.op);
    assign shamt    = bus.b[SHAMT_W-1:0];
    assign step_amt = (rem_q > SHAMT_W'(SHIFT_STEP)) ? STEP_W'(SHIFT_STEP) : rem_q[STEP_W-1:0];

    // The result register doubles as the shift accumulator while in SHIFT.
    alu_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (SHIFT_STEP),
        .AMT_W (STEP_W)
    ) u_shift_step (
        .data     (result_q),
        .amt      (step_amt),
        .right    (op_q != OP_SLL),
        .arith    (op_q == OP_SRA),
        .data_out (step_data),
        .out_bit  (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rem_d      = rem_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        err_d      = err_q;
        upd        = 1'b0;
        b_eff      = '0;
        sum        = '0;

        case (state_q)
            SHIFT: begin
                result_d = step_data;
                carry_d  = step_bit;
                rem_d    = rem_q - SHAMT_W'(step_amt);
                upd      = 1'b1;
                if (rem_q <= SHAMT_W'(SHIFT_STEP)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A new request overrides the DONE->IDLE return (back-to-back accept).
        if (accept) begin
            state_d    = DONE;
            op_d       = op_in;
            carry_d    = 1'b0;
            overflow_d = 1'b0;
            err_d      = 1'b0;
            upd        = 1'b1;
            case (op_in)
                OP_ADD, OP_SUB: begin
                    b_eff      = (op_in == OP_SUB) ? ~bus.b : bus.b;
                    sum        = {1'b0, bus.a} + {1'b0, b_eff} + (WIDTH+1)'(bus.cin);
                    result_d   = sum[WIDTH-1:0];
                    carry_d    = sum[WIDTH];
                    overflow_d = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                 (sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_AND: result_d = bus.a & bus.b;
                OP_OR:  result_d = bus.a | bus.b;
                OP_XOR: result_d = bus.a ^ bus.b;
                OP_NOR: result_d = ~(bus.a | bus.b);
                OP_SLL, OP_SRL, OP_SRA: begin
                    result_d = bus.a;
                    if (shamt != '0) begin
                        state_d = SHIFT;
                        rem_d   = shamt;
                    end
                end
                default: begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
            endcase
        end

        if (upd) begin
            zero_d     = (result_d == '0);
            negative_d = result_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_ADD;
            rem_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            op_q       <= op_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand/result width (>=8, power of two).
REQ-002 The module SHALL have parameter SHIFT_STEP, default 4, max shift bits per cycle (1..WIDTH/2, power of two).
REQ-003 The module SHALL have port clk  input  1  single clock, rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid  input  1  request valid.
REQ-006 The module SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are high.
REQ-007 The module SHALL have port op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9-15 illegal.
REQ-008 The module SHALL have ports a, b  input  WIDTH  operands; b[log2(WIDTH)-1:0] is the shift amount for shifts.
REQ-009 The module SHALL have port cin  input  1  carry-in, used by ADD/SUB only.
REQ-010 The module SHALL have port out_valid  output  1  result valid.
REQ-011 The module SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are high.
REQ-012 The module SHALL have port result  output  WIDTH  registered result.
REQ-013 The module SHALL have ports carry, overflow, zero, negative, err  output  1 each  registered flags.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, DONE; in_ready = (IDLE) or (DONE and out_ready).
REQ-015 On accept, a, b, op and cin SHALL be captured; later input changes SHALL NOT affect the operation.
REQ-016 Non-shift ops and shifts with amount 0 SHALL go to DONE, with out_valid high on the cycle after accept (latency 1).
REQ-017 Shifts with amount N>0 SHALL go to SHIFT, shift by min(SHIFT_STEP, remaining) per cycle, and enter DONE after the final step; latency = 1 + ceil(N/SHIFT_STEP).
REQ-018 ADD SHALL compute a+b+cin; SUB SHALL compute a+~b+cin (cin=1 gives true a-b); carry = MSB carry-out; overflow = signed overflow.
REQ-019 Logic ops SHALL clear carry and overflow.
REQ-020 Shifts SHALL set carry to the last bit shifted out (0 when N=0) and clear overflow; SRA SHALL replicate a[WIDTH-1].
REQ-021 zero SHALL equal (result==0) and negative SHALL equal result[WIDTH-1] for every op.
REQ-022 Illegal op SHALL give result 0, err 1, zero 1, all other flags 0, latency 1; err SHALL be 0 for legal ops.
REQ-023 In DONE with out_ready low, result and all flags SHALL hold stable and in_ready SHALL be 0.
REQ-024 In DONE with out_ready high and in_valid high, the new request SHALL be accepted in the same cycle (back-to-back); otherwise the FSM SHALL return to IDLE.
REQ-025 out_valid SHALL be high exactly in DONE.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, out_valid 0, result 0, and all flags 0; in_ready SHALL be 1 after release.
REQ-027 Reset during SHIFT or DONE SHALL abort the operation with no result delivered.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode enum and the FSM state enum.
REQ-029 One sub-module, alu_shift_step (combinational: one step of up to SHIFT_STEP bits, with direction/arithmetic select and shifted-out bit), SHALL be instantiated once.

Verification (WIDTH=32, SHIFT_STEP=4)
REQ-030 ADD a=0xFFFFFFFF b=1 cin=0 -> result 0x00000000, carry 1, zero 1, overflow 0, out_valid the cycle after accept.
REQ-031 SUB a=0x80000000 b=1 cin=1 -> result 0x7FFFFFFF, carry 1, overflow 1, negative 0.
REQ-032 SRA a=0x80000000 b=5 -> out_valid 3 cycles after accept, result 0xFC000000, carry 0, negative 1.
REQ-033 SLL a=1 b=0 with out_ready low 3 cycles -> latency 1, result 1 held stable, in_ready 0 until out_ready rises.
REQ-034 SLL b=31 with rst_n pulsed low during SHIFT -> out_valid 0 immediately, in_ready 1 after release; a following ADD 2+3 returns 5.
REQ-035 in_valid held with out_ready=1 for ops AND, op 12 -> second request accepted on the first result handshake; second result err 1, zero 1.
